shot_scorer: RTL

SHOT_SCORER -- requirements
Module: shot_scorer

---
 rtl/shot_scorer_if.sv | 23 ++
 rtl/shot_scorer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/shot_scorer_if.sv
// rtl/shot_scorer_if.sv - ball sample inputs and shot result outputs of the scorer
interface shot_scorer_if;
  logic       tick;
  logic       released;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       result_valid;
  logic [1:0] result_code;
  logic       bank;
  logic [7:0] score;
  logic [7:0] attempts;
  logic       busy;

  modport master (
    output tick, released, ball_x, ball_y,
    input  result_valid, result_code, bank, score, attempts, busy
  );

  modport slave (
    input  tick, released, ball_x, ball_y,
    output result_valid, result_code, bank, score, attempts, busy
  );
endinterface

// File: rtl/shot_scorer.sv
// rtl/shot_scorer.sv - decides make/miss/timeout per shot and keeps saturating tallies
module shot_scorer #(
  parameter int HOOP_X_L    = 610,
  parameter int HOOP_X_R    = 630,
  parameter int HOOP_Y_T    = 155,
  parameter int HOOP_Y_B    = 159,
  parameter int BOARD_X_L   = 630,
  parameter int BOARD_Y_T   = 110,
  parameter int BOARD_Y_B   = 160,
  parameter int BALL_RADIUS = 4,
  parameter int FLOOR_Y     = 479,
  parameter int WALL_X      = 639,
  parameter int TIMEOUT     = 1023
) (
  input logic        clk,
  input logic        rst,
  shot_scorer_if.slave bus
);

  localparam logic [9:0]  HXL      = 10'(HOOP_X_L);
  localparam logic [9:0]  HXR      = 10'(HOOP_X_R);
  localparam logic [9:0]  HYT      = 10'(HOOP_Y_T);
  localparam logic [9:0]  RIM_LOW  = 10'(HOOP_Y_B + BALL_RADIUS);
  localparam logic [10:0] BXL      = 11'(BOARD_X_L);
  localparam logic [9:0]  BYT      = 10'(BOARD_Y_T);
  localparam logic [9:0]  BYB      = 10'(BOARD_Y_B);
  localparam logic [10:0] RAD      = 11'(BALL_RADIUS);
  localparam logic [9:0]  FLOOR    = 10'(FLOOR_Y);
  localparam logic [9:0]  WALL     = 10'(WALL_X);
  localparam logic [10:0] TMO      = 11'(TIMEOUT);

  localparam logic [1:0] CODE_MAKE = 2'b01;
  localparam logic [1:0] CODE_MISS = 2'b10;
  localparam logic [1:0] CODE_TMO  = 2'b11;

  typedef enum logic [1:0] {IDLE, FLIGHT, ABOVE, DONE} state_t;

  state_t     state, state_n;
  logic [9:0] tcnt, tcnt_n;
  logic       bank_seen, bank_seen_n;
  logic       rv_q, rv_n;
  logic [1:0] code_q, code_n;
  logic       bank_q, bank_n;
  logic [7:0] score_q, score_n;
  logic [7:0] att_q, att_n;
  logic       busy_q, busy_n;

  logic        in_span, above_rim, rim_make, tunnel_make, make;
  logic        off_court, board_hit, timeout_hit;
  logic [10:0] tcnt_inc;
  logic        decide;
  logic [1:0]  dcode;

  assign in_span     = (bus.ball_x >= HXL) && (bus.ball_x < HXR);
  assign above_rim   = bus.ball_y < HYT;
  // A fast ball may skip the rim rows between two samples; still a make if it stayed inside the span.
  assign rim_make    = in_span && (bus.ball_y >= HYT) && (bus.ball_y <= RIM_LOW);
  assign tunnel_make = in_span && (bus.ball_y > RIM_LOW);
  assign make        = rim_make || tunnel_make;
  assign off_court   = (bus.ball_y >= FLOOR) || (bus.ball_x >= WALL);
  assign board_hit   = (({1'b0, bus.ball_x} + RAD) >= BXL) &&
                       (bus.ball_y >= BYT) && (bus.ball_y <= BYB);
  assign tcnt_inc    = {1'b0, tcnt} + 11'd1;
  assign timeout_hit = tcnt_inc >= TMO;

  always_comb begin
    state_n     = state;
    tcnt_n      = tcnt;
    bank_seen_n = bank_seen;
    rv_n        = 1'b0;
    code_n      = code_q;
    bank_n      = bank_q;
    score_n     = score_q;
    att_n       = att_q;
    decide      = 1'b0;
    dcode       = 2'b00;

    case (state)
      IDLE: begin
        if (bus.tick && bus.released) begin
          state_n     = FLIGHT;
          tcnt_n      = '0;
          bank_seen_n = 1'b0;
        end
      end
      FLIGHT, ABOVE: begin
        if (!bus.released) begin
          state_n = IDLE;
        end else if (bus.tick) begin
          tcnt_n      = tcnt_inc[9:0];
          bank_seen_n = bank_seen | board_hit;
          if (state == ABOVE && make) begin
            decide = 1'b1;
            dcode  = CODE_MAKE;
          end else if (off_court) begin
            decide = 1'b1;
            dcode  = CODE_MISS;
          end else if (timeout_hit) begin
            decide = 1'b1;
            dcode  = CODE_TMO;
          end else if (state == FLIGHT && in_span && above_rim) begin
            state_n = ABOVE;
          end else if (state == ABOVE && !in_span) begin
            state_n = FLIGHT;
          end
        end
      end
      DONE: begin
        if (!bus.released) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (decide) begin
      state_n = DONE;
      rv_n    = 1'b1;
      code_n  = dcode;
      bank_n  = bank_seen | board_hit;
      att_n   = (att_q == 8'hFF) ? att_q : att_q + 8'd1;
      if (dcode == CODE_MAKE)
        score_n = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
    end

    busy_n = (state_n == FLIGHT) || (state_n == ABOVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      bank_seen <= 1'b0;
      rv_q      <= 1'b0;
      code_q    <= 2'b00;
      bank_q    <= 1'b0;
      score_q   <= '0;
      att_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      tcnt      <= tcnt_n;
      bank_seen <= bank_seen_n;
      rv_q      <= rv_n;
      code_q    <= code_n;
      bank_q    <= bank_n;
      score_q   <= score_n;
      att_q     <= att_n;
      busy_q    <= busy_n;
    end
  end

  assign bus.result_valid = rv_q;
  assign bus.result_code  = code_q;
  assign bus.bank         = bank_q;
  assign bus.score        = score_q;
  assign bus.attempts     = att_q;
  assign bus.busy         = busy_q;

endmodule
